remove_cp: RTL

// - Receive-side cyclic-prefix removal; inverse of the transmit-side CP insertion block.
// - Takes LCP+NFFT complex samples per OFDM symbol from the timing-sync stage.
// - Discards the first LCP samples (the CP) and forwards the NFFT useful samples to the FFT.
// - Each forwarded symbol is framed with SOF_O/EOF_O; loss of symbol alignment is flagged.

---
 rtl/remove_cp_pkg.sv | 17 +
 rtl/remove_cp.sv | 135 +++++++++++++
 2 files changed

// File: rtl/remove_cp_pkg.sv
// Shared definitions for OFDM cyclic-prefix handling: default symbol geometry
// and the receive-side CP-removal FSM state encoding.
package remove_cp_pkg;

  localparam int unsigned LCP_DEF     = 16;
  localparam int unsigned NFFT_DEF    = 48;
  localparam int unsigned DW_DEF      = 16;
  localparam int unsigned CW_DEF      = $clog2(LCP_DEF + NFFT_DEF);
  localparam int unsigned SYM_CNT_W   = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DROP = 2'd1,
    ST_PASS = 2'd2
  } state_t;

endpackage

// File: rtl/remove_cp.sv
// Receive-side cyclic-prefix removal: drops the first LCP samples of each
// symbol, forwards the NFFT useful samples framed with SOF_O/EOF_O.
module remove_cp
  import remove_cp_pkg::*;
#(
  parameter int unsigned LCP  = LCP_DEF,
  parameter int unsigned NFFT = NFFT_DEF,
  parameter int unsigned DW   = DW_DEF,
  parameter int unsigned CW   = CW_DEF
) (
  input  logic                 CLK_I,
  input  logic                 RST_I,
  input  logic [DW-1:0]        DAT_I_r,
  input  logic [DW-1:0]        DAT_I_i,
  input  logic                 STB_I,
  input  logic                 SOF_I,
  output logic                 ACK_O,
  output logic [DW-1:0]        DAT_O_r,
  output logic [DW-1:0]        DAT_O_i,
  output logic                 STB_O,
  output logic                 SOF_O,
  output logic                 EOF_O,
  input  logic                 ACK_I,
  output logic                 ERR_O,
  output logic [SYM_CNT_W-1:0] SYM_CNT_O
);

  localparam logic [CW-1:0] POS_LAST_CP = CW'(LCP - 1);
  localparam logic [CW-1:0] POS_FIRST   = CW'(LCP);
  localparam logic [CW-1:0] POS_LAST    = CW'(LCP + NFFT - 1);
  // A SOF sample is CP sample 0; with a one-sample CP the next one is useful.
  localparam state_t ST_AFTER_SOF = (LCP == 1) ? ST_PASS : ST_DROP;

  state_t        state, state_n;
  logic [CW-1:0] pos, pos_n;
  logic          xfer;
  logic          load;
  logic          sof_n, eof_n, err_n, cnt_inc;

  // Only PASS can stall, and only when the output register is full and blocked.
  assign ACK_O = (state != ST_PASS) | ~STB_O | ACK_I;
  assign xfer  = STB_I & ACK_O;

  // Next-state, position and output-register load control.
  always_comb begin
    state_n = state;
    pos_n   = pos;
    load    = 1'b0;
    sof_n   = 1'b0;
    eof_n   = 1'b0;
    err_n   = 1'b0;
    cnt_inc = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (xfer && SOF_I) begin
          pos_n   = CW'(1);
          state_n = ST_AFTER_SOF;
        end
      end
      ST_DROP: begin
        if (xfer) begin
          if (SOF_I && (pos != '0)) begin
            err_n   = 1'b1;
            pos_n   = CW'(1);
            state_n = ST_AFTER_SOF;
          end else begin
            pos_n = pos + CW'(1);
            if (pos == POS_LAST_CP) state_n = ST_PASS;
          end
        end
      end
      ST_PASS: begin
        if (xfer) begin
          if (SOF_I) begin
            err_n   = 1'b1;
            pos_n   = CW'(1);
            state_n = ST_AFTER_SOF;
          end else begin
            load  = 1'b1;
            sof_n = (pos == POS_FIRST);
            eof_n = (pos == POS_LAST);
            if (pos == POS_LAST) begin
              pos_n   = '0;
              cnt_inc = 1'b1;
              state_n = ST_DROP;
            end else begin
              pos_n = pos + CW'(1);
            end
          end
        end
      end
      default: begin
        state_n = ST_IDLE;
        pos_n   = '0;
      end
    endcase
  end

  // State, position and status registers.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state     <= ST_IDLE;
      pos       <= '0;
      ERR_O     <= 1'b0;
      SYM_CNT_O <= '0;
    end else begin
      state <= state_n;
      pos   <= pos_n;
      ERR_O <= err_n;
      if (cnt_inc) SYM_CNT_O <= SYM_CNT_O + SYM_CNT_W'(1);
    end
  end

  // Single-entry output register; holds until downstream accepts.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      DAT_O_r <= '0;
      DAT_O_i <= '0;
      STB_O   <= 1'b0;
      SOF_O   <= 1'b0;
      EOF_O   <= 1'b0;
    end else if (load) begin
      DAT_O_r <= DAT_I_r;
      DAT_O_i <= DAT_I_i;
      STB_O   <= 1'b1;
      SOF_O   <= sof_n;
      EOF_O   <= eof_n;
    end else if (STB_O && ACK_I) begin
      STB_O <= 1'b0;
      SOF_O <= 1'b0;
      EOF_O <= 1'b0;
    end
  end

endmodule
